// File: rtl/noc_pkg.sv
// Shared constants and helpers for the round-robin word multiplexer and its channel FIFOs.
package noc_pkg;

  localparam int WORD_WIDTH_DEF = 16;
  localparam int VAL_BIT_DEF    = 1;
  localparam int DROP_CNT_W     = 8;

  // Source-index width; never below one bit so a port always exists.
  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage; a push becomes visible as not-empty one cycle later.
module sync_fifo #(
  parameter int WIDTH     = 15,
  parameter int LOG_DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 2 ** LOG_DEPTH;
  localparam logic [LOG_DEPTH:0] PTR_ONE = 1;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [LOG_DEPTH:0] wr_ptr;
  logic [LOG_DEPTH:0] rd_ptr;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[LOG_DEPTH] != rd_ptr[LOG_DEPTH]) &&
                 (wr_ptr[LOG_DEPTH-1:0] == rd_ptr[LOG_DEPTH-1:0]);
  assign rdata = mem[rd_ptr[LOG_DEPTH-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty)
        rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[LOG_DEPTH-1:0]] <= wdata;
  end

endmodule

// File: rtl/rr_tree_mux.sv
// N_IN-channel buffered round-robin multiplexer onto one registered output word.
// Optional per-channel drop counters are enabled with the macro RR_TREE_MUX_DROP_STATS_EN.
module rr_tree_mux
  import noc_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int VAL_BIT    = VAL_BIT_DEF,
  parameter int N_IN       = 4,
  parameter int LOG_DEPTH  = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         busy,
  input  logic [N_IN*WORD_WIDTH-1:0]   in_data,
  output logic [N_IN-1:0]              full,
  output logic [WORD_WIDTH-1:0]        out,
  output logic [src_w(N_IN)-1:0]       out_src,
  output logic [N_IN*DROP_CNT_W-1:0]   drop_cnt
);

  localparam int PW = WORD_WIDTH - VAL_BIT;
  localparam int SW = src_w(N_IN);

  logic            armed;
  logic [N_IN-1:0] vld_in;
  logic [N_IN-1:0] push;
  logic [N_IN-1:0] pop;
  logic [N_IN-1:0] fifo_full;
  logic [N_IN-1:0] fifo_empty;
  logic [PW-1:0]   rdata [N_IN];

  logic            gnt_vld;
  logic [SW-1:0]   gnt_idx;
  logic [PW-1:0]   gnt_data;
  logic [SW-1:0]   ptr;
  logic [SW-1:0]   ptr_nxt;

  // Held low through the first edge after reset release so that edge ignores inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) armed <= 1'b0;
    else      armed <= 1'b1;
  end

  for (genvar g = 0; g < N_IN; g++) begin : g_ch
    assign vld_in[g] = |in_data[g*WORD_WIDTH+PW +: VAL_BIT];
    assign push[g]   = vld_in[g] & armed;

    sync_fifo #(
      .WIDTH    (PW),
      .LOG_DEPTH(LOG_DEPTH)
    ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (push[g]),
      .pop  (pop[g]),
      .wdata(in_data[g*WORD_WIDTH +: PW]),
      .rdata(rdata[g]),
      .full (fifo_full[g]),
      .empty(fifo_empty[g])
    );
  end

  assign full = fifo_full | {N_IN{busy}};

  // Scan ptr, ptr+1, ... with explicit modulo so non-power-of-two counts wrap correctly.
  always_comb begin
    int idx;
    idx      = 0;
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    gnt_data = '0;
    for (int k = 0; k < N_IN; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_IN) idx = idx - N_IN;
      if (!gnt_vld && !fifo_empty[idx]) begin
        gnt_vld  = 1'b1;
        gnt_idx  = SW'(idx);
        gnt_data = rdata[idx];
      end
    end
  end

  assign ptr_nxt = (gnt_idx == SW'(N_IN - 1)) ? '0 : gnt_idx + SW'(1);

  always_comb begin
    pop = '0;
    if (gnt_vld && !busy) pop[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out     <= '0;
      out_src <= '0;
      ptr     <= '0;
    end else if (!busy) begin
      if (gnt_vld) begin
        out     <= {{VAL_BIT{1'b1}}, gnt_data};
        out_src <= gnt_idx;
        ptr     <= ptr_nxt;
      end else begin
        out[WORD_WIDTH-1 -: VAL_BIT] <= '0;
      end
    end
  end

`ifdef RR_TREE_MUX_DROP_STATS_EN
  logic [DROP_CNT_W-1:0] drop_q [N_IN];

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + DROP_CNT_W'(1);
  endfunction

  // A drop is a valid, armed word meeting a FIFO already full before any same-cycle pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_IN; i++) drop_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++)
        if (push[i] && fifo_full[i]) drop_q[i] <= sat_inc(drop_q[i]);
    end
  end

  for (genvar g = 0; g < N_IN; g++) begin : g_drop
    assign drop_cnt[g*DROP_CNT_W +: DROP_CNT_W] = drop_q[g];
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_rr_tree_mux.sv
// Directed bench: a 4-channel and a 3-channel rr_tree_mux instance on a shared clock and reset.
module tb_rr_tree_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy_a, busy_b;
  logic [63:0] in_a;
  logic [47:0] in_b;
  logic [3:0]  full_a;
  logic [2:0]  full_b;
  logic [15:0] out_a, out_b;
  logic [1:0]  src_a, src_b;
  logic [31:0] drop_a;
  logic [23:0] drop_b;

  int checks = 0;
  int errors = 0;

`ifdef RR_TREE_MUX_DROP_STATS_EN
  localparam logic [7:0] EXP_DROP = 8'd2;
`else
  localparam logic [7:0] EXP_DROP = 8'd0;
`endif

  always #5 clk = ~clk;

  rr_tree_mux #(.WORD_WIDTH(16), .VAL_BIT(1), .N_IN(4), .LOG_DEPTH(3)) dut_a (
    .clk(clk), .rst(rst), .busy(busy_a), .in_data(in_a),
    .full(full_a), .out(out_a), .out_src(src_a), .drop_cnt(drop_a)
  );

  rr_tree_mux #(.WORD_WIDTH(16), .VAL_BIT(1), .N_IN(3), .LOG_DEPTH(3)) dut_b (
    .clk(clk), .rst(rst), .busy(busy_b), .in_data(in_b),
    .full(full_b), .out(out_b), .out_src(src_b), .drop_cnt(drop_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] words [4];
    words[0] = 16'h8101;
    words[1] = 16'h8202;
    words[2] = 16'h8303;
    words[3] = 16'h8404;

    rst = 1'b0; busy_a = 1'b0; busy_b = 1'b0; in_a = '0; in_b = '0;
    step(); step();
    check("rst_out", 32'(out_a), 32'h0);
    check("rst_src", 32'(src_a), 32'h0);
    check("rst_full", 32'(full_a), 32'h0);
    check("rst_drop", drop_a, 32'h0);
    check("rst_out_b", 32'(out_b), 32'h0);
    rst = 1'b1;
    step();

    // single word on channel 2
    in_a[32 +: 16] = 16'h8ABC;
    step();
    in_a = '0;
    check("single_lat1", 32'(out_a[15]), 32'h0);
    step();
    check("single_out", 32'(out_a), 32'h8ABC);
    check("single_src", 32'(src_a), 32'h2);
    step();
    check("single_after", 32'(out_a), 32'h0ABC);
    check("single_after_src", 32'(src_a), 32'h2);

    // continuous load on all channels; pointer sits at 3 after the single word
    in_a = {words[3], words[2], words[1], words[0]};
    step();
    check("rr_first_empty", 32'(out_a[15]), 32'h0);
    for (int k = 0; k < 8; k++) begin
      step();
      check("rr_src", 32'(src_a), 32'((3 + k) % 4));
      check("rr_out", 32'(out_a), 32'(words[(3 + k) % 4]));
    end

    // busy hold with inputs idle
    busy_a = 1'b1;
    in_a = '0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("busy_out", 32'(out_a), 32'h8303);
      check("busy_src", 32'(src_a), 32'h2);
      check("busy_full", 32'(full_a), 32'hF);
    end
    busy_a = 1'b0;
    step();
    check("busy_release_src", 32'(src_a), 32'h3);
    check("busy_release_out", 32'(out_a), 32'h8404);

    // reset mid-stream with FIFOs populated
    rst = 1'b0;
    #1;
    check("midrst_out", 32'(out_a), 32'h0);
    check("midrst_full", 32'(full_a), 32'h0);
    check("midrst_src", 32'(src_a), 32'h0);
    step();
    in_a[16 +: 16] = 16'h8555;
    rst = 1'b1;
    step();
    in_a = '0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("midrst_no_stale", 32'(out_a), 32'h0);
    end

    // overflow: 10 words into channel 0 while busy
    busy_a = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_a[15:0] = 16'h8000 | 16'(k * 16'h11);
      step();
    end
    in_a = '0;
    check("ovf_drop0", 32'(drop_a[7:0]), 32'(EXP_DROP));
    check("ovf_drop_others", 32'(drop_a[31:8]), 32'h0);
    check("ovf_full_busy", 32'(full_a), 32'hF);
    busy_a = 1'b0;
    #1;
    check("ovf_full_fifo", 32'(full_a), 32'h1);
    check("ovf_out_idle", 32'(out_a[15]), 32'h0);
    for (int k = 0; k < 8; k++) begin
      step();
      check("ovf_drain_out", 32'(out_a), 32'(16'h8000 | 16'(k * 16'h11)));
      check("ovf_drain_src", 32'(src_a), 32'h0);
    end
    step();
    check("ovf_drained", 32'(out_a[15]), 32'h0);

    // N_IN=3: a channel-1 word parks the pointer at 2, then channels 2 and 0 compete
    in_b[16 +: 16] = 16'h8111;
    step();
    in_b = '0;
    step();
    check("wrap_pre_src", 32'(src_b), 32'h1);
    check("wrap_pre_out", 32'(out_b), 32'h8111);
    in_b = {16'h8C02, 16'h0000, 16'h8A00};
    step();
    check("wrap_first_empty", 32'(out_b[15]), 32'h0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("wrap_src", 32'(src_b), (k % 2 == 0) ? 32'h2 : 32'h0);
      check("wrap_out", 32'(out_b), (k % 2 == 0) ? 32'h8C02 : 32'h8A00);
    end
    in_b = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_tree_mux.md
RR_TREE_MUX -- requirements
Module: rr_tree_mux

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 16, meaning full word width including the valid field.
REQ-002 SHALL have parameter VAL_BIT, default 1, meaning valid-field width, located in the word MSBs.
REQ-003 SHALL have parameter N_IN, default 4, meaning input channel count, legal range 2..16, not restricted to powers of two.
REQ-004 SHALL have parameter LOG_DEPTH, default 3, meaning log2 of per-channel FIFO depth.
REQ-005 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port busy, input, 1 bit: downstream cannot accept a word this cycle.
REQ-008 SHALL have port in_data, input, N_IN*WORD_WIDTH bits: channel i occupies bits [i*WORD_WIDTH +: WORD_WIDTH].
REQ-009 SHALL have port full, output, N_IN bits: per-channel backpressure to upstream.
REQ-010 SHALL have port out, output, WORD_WIDTH bits: registered word with valid field in the MSBs.
REQ-011 SHALL have port out_src, output, $clog2(N_IN) bits: registered index of the channel that sourced out.
REQ-012 SHALL have port drop_cnt, output, N_IN*8 bits: per-channel 8-bit dropped-word counters.

Function
REQ-013 SHALL push payload in_data[i][WORD_WIDTH-VAL_BIT-1:0] into FIFO i when channel i's valid field is nonzero and FIFO i is not full.
REQ-014 SHALL discard a valid input word arriving while FIFO i is full; full status is sampled before any same-cycle pop, so there is no pop-to-push bypass.
REQ-015 SHALL make a pushed word visible as FIFO not-empty one cycle after the push, with no empty-FIFO bypass.
REQ-016 SHALL drive full[i] = fifo_full[i] | busy, combinationally.
REQ-017 SHALL hold a round-robin pointer ptr in range 0..N_IN-1 and, when busy=0, grant the first non-empty channel g scanning ptr, ptr+1, ... modulo N_IN.
REQ-018 SHALL, on a grant with busy=0, pop FIFO g, load out <= {valid all-ones, payload}, load out_src <= g, and set ptr <= (g+1) mod N_IN with correct wrap for non-power-of-two N_IN.
REQ-019 SHALL, when busy=0 and all FIFOs are empty, clear out's valid field while holding out's payload, out_src and ptr unchanged.
REQ-020 SHALL, when busy=1, hold out, out_src and ptr and perform no pop.
REQ-021 SHALL treat a word as transferred at a rising edge where out is valid and busy=0.
REQ-022 SHALL give a minimum latency from input word to out of 2 cycles.
REQ-023 SHALL, under continuous load on all channels, grant each channel exactly once per N_IN consecutive non-busy cycles.

Reset
REQ-024 SHALL, while rst=0, asynchronously clear out, out_src, ptr, drop_cnt and all FIFO pointers to 0; all FIFOs then report empty.
REQ-025 SHALL discard any FIFO contents and the in-flight out word when rst asserts mid-operation, with no partial transfer.
REQ-026 SHALL ignore inputs during the first edge after rst deasserts.

Configuration
REQ-027 SHALL, with RR_TREE_MUX_DROP_STATS_EN defined, increment drop_cnt[i] by one for each word discarded per REQ-014, saturating at 255.
REQ-028 SHALL, without RR_TREE_MUX_DROP_STATS_EN, keep the drop_cnt port present and drive it constant 0, with no counter flops.

Structure
REQ-029 SHALL place WORD_WIDTH/VAL_BIT defaults, the drop-counter width constant, and a source-index width function in the shared package noc_pkg.
REQ-030 SHALL implement each channel buffer as one instance of sub-module sync_fifo, parametrised by width and depth, with push, pop, full and empty signals.

Verification
REQ-031 SHALL verify single word: N_IN=4; channel 2 sends 0x8ABC at cycle 0 -> out=0x8ABC and out_src=2 at cycle 2, then out valid=0.
REQ-032 SHALL verify round-robin: all 4 channels loaded continuously, busy=0 -> out_src sequence 0,1,2,3,0,... with no repeats or skips.
REQ-033 SHALL verify busy hold: busy=1 for 5 cycles while out is valid -> out, out_src and FIFO levels unchanged and full=all-ones; the held word transfers on the first busy=0 edge.
REQ-034 SHALL verify overflow: LOG_DEPTH=3; 10 back-to-back words into channel 0 with busy=1 -> 8 stored, drop_cnt[0]=2 with the macro defined and 0 without it.
REQ-035 SHALL verify wrap with non-power-of-two N_IN: N_IN=3; only channels 2 and 0 active -> out_src alternates 2,0,2,0.
REQ-036 SHALL verify reset mid-stream: rst=0 pulse while FIFOs are half full -> out=0, full=0, and no stale words appear after release.
